uart_transmitter: RTL and testbench

Serialises bytes onto a UART line: 8 data bits, LSB first, one start bit, one stop bit, no parity. It sits on the FPGA side of the board's serial link and pairs with the existing UART receiver, which samples the same frame format at the same `CYCLES_PER_BIT`. A one-byte holding register lets upstream logic queue the next byte while the current frame shifts out, so frames can run back-to-back with no idle gap.

---
 rtl/uart_transmitter_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 41 ++++
 rtl/uart_transmitter.sv | 140 ++++++++++++++
 tb/tb_uart_transmitter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: frame states and the default bit period.
// The receiver imports the same package so both ends agree on encoding.
package uart_transmitter_pkg;

    // 115200 baud at 25 MHz.
    localparam int CYCLES_PER_BIT_DEFAULT = 217;
    localparam int DATA_BITS              = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 while enabled and raises
// o_tick on the final cycle of each bit period. Held at 0 while disabled,
// so the first period after enabling is a full one.
module uart_bit_timer
    import uart_transmitter_pkg::*;
#(
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    output logic o_tick
);

    localparam int              CW  = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0]   TOP = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at the top value, park at zero when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (!i_en || cnt_q == TOP) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_en && (cnt_q == TOP);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1, LSB first, with a one-byte holding register so
// the next byte can be queued while the current frame shifts out and
// frames run back-to-back.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_serial_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       tx_q, tx_d;
    logic       done_q, done_d;
    logic       tick;
    logic       accept;

    assign accept = i_tx_valid && !hold_full_q;

    uart_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT)
    ) u_timer (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_en   (state_q != ST_IDLE),
        .o_tick (tick)
    );

    // Frame sequencing, shift/holding register updates and the next line level.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_idx_d   = bit_idx_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // From idle the byte bypasses the holding register.
                if (accept) begin
                    shift_d = i_tx_byte;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (accept) begin
                    hold_d      = i_tx_byte;
                    hold_full_d = 1'b1;
                end
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    hold_d      = i_tx_byte;
                    hold_full_d = 1'b1;
                end
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    done_d = 1'b1;
                    if (hold_full_q) begin
                        // Queued byte starts immediately; accept is blocked here.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = ST_START;
                    end else if (accept) begin
                        // Late arrival on the last stop cycle: skip the holding register.
                        shift_d = i_tx_byte;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    hold_d      = i_tx_byte;
                    hold_full_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line is registered from the next state so it tracks state_q exactly.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign o_tx_ready  = !hold_full_q;
    assign o_serial_tx = tx_q;
    assign o_tx_busy   = (state_q != ST_IDLE);
    assign o_tx_done   = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at CYCLES_PER_BIT=4: hand-written frame tables,
// multi-cycle corner sequences, and a line-decoding reference receiver
// checking random and exhaustive byte streams.
module tb_uart_transmitter;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] byte_in;
    logic       ready, ser, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    uart_transmitter #(.CYCLES_PER_BIT(CPB)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_tx_valid (valid),
        .i_tx_byte  (byte_in),
        .o_tx_ready (ready),
        .o_serial_tx(ser),
        .o_tx_busy  (busy),
        .o_tx_done  (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- reference receiver ----------------
    bit         mon_en = 1'b0;
    bit         m_in   = 1'b0;
    int         m_cnt  = 0;
    logic [7:0] m_byte;
    logic [7:0] exp_q[$];
    int         n_rx   = 0;
    int         n_done = 0;

    always begin
        @(posedge clk);
        #1;
        if (!mon_en) begin
            m_in = 1'b0;
        end else begin
            if (done === 1'b1) n_done++;
            if (!m_in) begin
                if (ser === 1'b0) begin
                    m_in  = 1'b1;
                    m_cnt = 0;
                end
            end else begin
                m_cnt++;
            end
            if (m_in) begin
                if (m_cnt == CPB / 2)
                    chk("mon_start_bit", int'(ser), 0);
                if (m_cnt >= CPB + CPB / 2 && m_cnt < 9 * CPB && (m_cnt - CPB / 2) % CPB == 0)
                    m_byte[(m_cnt - CPB / 2) / CPB - 1] = ser;
                if (m_cnt == 9 * CPB + CPB / 2)
                    chk("mon_stop_bit", int'(ser), 1);
                if (m_cnt == 10 * CPB - 1) begin
                    m_in = 1'b0;
                    n_rx++;
                    if (exp_q.size() == 0) chk("mon_extra_frame", 1, 0);
                    else chk("mon_byte", int'(m_byte), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // Offer a byte and hold it until accepted; records the accept cycle.
    task automatic offer(input logic [7:0] d, output int acc);
        int k = 0;
        valid   = 1'b1;
        byte_in = d;
        while (!ready && k < 200) begin
            step();
            k++;
        end
        acc = cyc;
        if (k >= 200) begin
            chk("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back(d);
            step();
        end
        valid   = 1'b0;
        byte_in = 8'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 20000) begin
            step();
            k++;
        end
        chk("drain_timeout", int'(k < 20000), 1);
        step();
        step();
    endtask

    // Send one byte from idle and check every cycle of the frame.
    task automatic send_frame(input logic [7:0] d, input logic [9:0] f);
        chk("frame_ready_idle", int'(ready), 1);
        valid   = 1'b1;
        byte_in = d;
        step();
        valid   = 1'b0;
        for (int c = 1; c <= 10 * CPB; c++) begin
            chk("frame_line", int'(ser), int'(f[(c - 1) / CPB]));
            chk("frame_busy", int'(busy), 1);
            chk("frame_done_early", int'(done), 0);
            step();
        end
        chk("frame_done", int'(done), 1);
        chk("frame_busy_end", int'(busy), 0);
        chk("frame_line_end", int'(ser), 1);
        chk("frame_ready_end", int'(ready), 1);
        step();
        chk("frame_done_once", int'(done), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit, index 0 transmitted first
    } vec_t;

    vec_t vecs[6];

    initial begin
        int a1, a2, a3, dummy, base_done, base_rx, sent;
        logic [19:0] bb;
        logic [9:0]  f80;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h01, 10'b1000000010};
        vecs[4] = '{8'h80, 10'b1100000000};
        vecs[5] = '{8'h3C, 10'b1001111000};

        rst = 1'b1; valid = 1'b0; byte_in = 8'h00;
        step(); step(); step();
        chk("rst_line", int'(ser), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        step();
        chk("idle_line", int'(ser), 1);
        chk("idle_busy", int'(busy), 0);

        // Isolated frames from the table.
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].frame);
            step();
        end

        // Back-to-back: 0x00 then 0xFF with valid held high.
        bb = {10'b1111111110, 10'b1000000000};
        valid = 1'b1; byte_in = 8'h00;
        step();
        chk("b2b_ready_c1", int'(ready), 1);
        chk("b2b_line_c1", int'(ser), 0);
        byte_in = 8'hFF;
        step();
        valid = 1'b0;
        for (int c = 2; c <= 20 * CPB; c++) begin
            chk("b2b_line", int'(ser), int'(bb[(c - 1) / CPB]));
            chk("b2b_ready", int'(ready), (c <= 10 * CPB) ? 0 : 1);
            chk("b2b_done", int'(done), (c == 10 * CPB + 1) ? 1 : 0);
            chk("b2b_busy", int'(busy), 1);
            step();
        end
        chk("b2b_done2", int'(done), 1);
        chk("b2b_busy_end", int'(busy), 0);
        step();

        // Stop-cycle bypass: new byte offered only on the final stop cycle.
        f80 = 10'b1100000000;
        valid = 1'b1; byte_in = 8'h01;
        step();
        valid = 1'b0;
        while (cyc % 1 == 0 && busy && !(ser === 1'b1 && dut.u_timer.o_tick && 0)) begin
            break;
        end
        for (int c = 1; c < 10 * CPB; c++) step();
        chk("bypass_stop_line", int'(ser), 1);
        chk("bypass_ready", int'(ready), 1);
        valid = 1'b1; byte_in = 8'h80;
        step();
        valid = 1'b0;
        for (int c = 1; c <= 10 * CPB; c++) begin
            chk("bypass_line", int'(ser), int'(f80[(c - 1) / CPB]));
            chk("bypass_busy", int'(busy), 1);
            chk("bypass_done", int'(done), (c == 1) ? 1 : 0);
            step();
        end
        chk("bypass_done2", int'(done), 1);
        step();

        // Reset during data bit 3 with a byte queued.
        valid = 1'b1; byte_in = 8'hA5;
        step();
        byte_in = 8'h5A;
        step();
        valid = 1'b0;
        chk("rstmid_queued", int'(ready), 0);
        for (int c = 2; c < 18; c++) step();
        chk("rstmid_in_frame", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_line", int'(ser), 1);
        chk("rstmid_ready", int'(ready), 1);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_done", int'(done), 0);
        for (int c = 0; c < 50; c++) begin
            chk("rstmid_quiet_done", int'(done), 0);
            chk("rstmid_quiet_line", int'(ser), 1);
            step();
        end
        send_frame(vecs[5].data, vecs[5].frame);
        step();

        // Backpressure: three bytes offered continuously.
        mon_en = 1'b1;
        step();
        base_done = n_done; base_rx = n_rx;
        offer(8'h12, a1);
        offer(8'h34, a2);
        offer(8'h56, a3);
        chk("bp_second_accept", a2 - a1, 1);
        chk("bp_third_accept", a3 - a1, 10 * CPB + 1);
        drain();
        chk("bp_frames", n_rx - base_rx, 3);
        chk("bp_done_count", n_done - base_done, 3);

        // Random bytes with random idle gaps.
        base_done = n_done; base_rx = n_rx; sent = 0;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 50)) : 0;
            for (int g = 0; g < gap; g++) step();
            offer(8'($urandom), dummy);
            sent++;
        end
        drain();
        chk("rand_frames", n_rx - base_rx, sent);
        chk("rand_done_count", n_done - base_done, sent);

        // Loopback of every byte value.
        base_done = n_done; base_rx = n_rx;
        for (int v = 0; v < 256; v++) offer(8'(v), dummy);
        drain();
        chk("loop_frames", n_rx - base_rx, 256);
        chk("loop_done_count", n_done - base_done, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
